// File: rtl/aes_round_sequencer.sv
// Round/phase controller for the byte-serial AES-128 datapath: schedules
// key addition, SubBytes, ShiftRows and MixColumns over ROUNDS rounds.
module aes_round_sequencer #(
  parameter int unsigned ROUNDS = 10,
  parameter int unsigned SR_LAT = 13,
  parameter int unsigned MC_LAT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       key_valid,
  output logic       key_req,
  output logic       busy,
  output logic [2:0] stage_sel,
  output logic       capture,
  output logic       en_sr,
  output logic       en_mc,
  output logic [3:0] round,
  output logic [5:0] phase_cnt,
  output logic       done
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned RND_W = 4;
  localparam int unsigned BYTES = 16;

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] SR_FIRST  = CNT_W'(SR_LAT);
  localparam logic [CNT_W-1:0] SR_LAST   = CNT_W'(SR_LAT + BYTES - 1);
  localparam logic [CNT_W-1:0] MC_FIRST  = CNT_W'(MC_LAT);
  localparam logic [CNT_W-1:0] MC_LAST   = CNT_W'(MC_LAT + BYTES - 1);
  localparam logic [CNT_W-1:0] MC_COLS   = CNT_W'(BYTES);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(ROUNDS);

  localparam logic [2:0] SEL_HOLD   = 3'd0;
  localparam logic [2:0] SEL_IN_KEY = 3'd1;
  localparam logic [2:0] SEL_SUB    = 3'd2;
  localparam logic [2:0] SEL_SHIFT  = 3'd3;
  localparam logic [2:0] SEL_MIX    = 3'd4;
  localparam logic [2:0] SEL_ST_KEY = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD_INIT = 3'd1,
    S_SUB      = 3'd2,
    S_SHIFT    = 3'd3,
    S_MIX      = 3'd4,
    S_ADD_RK   = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               more_rounds;

  assign more_rounds = (round_q < RND_LAST);

  // State, round and phase counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, round and phase counter
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        round_d = '0;
        cnt_d   = '0;
        if (start) state_d = S_ADD_INIT;
      end
      S_ADD_INIT, S_ADD_RK: begin
        // Key phases advance only on an accepted key byte
        if (key_valid) begin
          if (cnt_q == BYTE_LAST) begin
            cnt_d = '0;
            if ((state_q == S_ADD_INIT) || more_rounds) begin
              state_d = S_SUB;
              round_d = round_q + RND_W'(1);
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_SUB: begin
        if (cnt_q == BYTE_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == SR_LAST) begin
          cnt_d   = '0;
          state_d = more_rounds ? S_MIX : S_ADD_RK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MIX: begin
        if (cnt_q == MC_LAST) begin
          cnt_d   = '0;
          state_d = S_ADD_RK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath controls decoded from state; key-phase capture follows key_valid
  always_comb begin
    key_req   = 1'b0;
    busy      = (state_q != S_IDLE);
    stage_sel = SEL_HOLD;
    capture   = 1'b0;
    en_sr     = 1'b0;
    en_mc     = 1'b0;
    round     = round_q;
    phase_cnt = cnt_q;
    done      = 1'b0;
    case (state_q)
      S_ADD_INIT: begin
        key_req   = 1'b1;
        capture   = key_valid;
        stage_sel = SEL_IN_KEY;
      end
      S_ADD_RK: begin
        key_req   = 1'b1;
        capture   = key_valid;
        stage_sel = SEL_ST_KEY;
      end
      S_SUB: begin
        capture   = 1'b1;
        stage_sel = SEL_SUB;
      end
      S_SHIFT: begin
        en_sr     = 1'b1;
        capture   = (cnt_q >= SR_FIRST);
        stage_sel = SEL_SHIFT;
      end
      S_MIX: begin
        // Engine idles on the first cycle of each of the four column slots
        en_mc     = (cnt_q[1:0] != 2'd0) || (cnt_q >= MC_COLS);
        capture   = (cnt_q >= MC_FIRST);
        stage_sel = SEL_MIX;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        key_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: a phase-schedule model predicts
// every busy cycle's outputs; a negedge monitor compares what the DUT shows.
module tb_aes_round_sequencer;

  localparam int ROUNDS   = 10;
  localparam int SR_LAT   = 13;
  localparam int MC_LAT   = 4;
  localparam int BASE_LAT = 806;

  localparam int K_INIT  = 0;
  localparam int K_SUB   = 1;
  localparam int K_SHIFT = 2;
  localparam int K_MIX   = 3;
  localparam int K_ARK   = 4;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       key_req;
    logic       capture;
    logic       en_sr;
    logic       en_mc;
    logic [2:0] sel;
    logic [3:0] rnd;
    logic [5:0] cnt;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic       clock, reset, start, key_valid;
  logic       key_req, busy, capture, en_sr, en_mc, done;
  logic [2:0] stage_sel;
  logic [3:0] round;
  logic [5:0] phase_cnt;

  aes_round_sequencer #(.ROUNDS(ROUNDS), .SR_LAT(SR_LAT), .MC_LAT(MC_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .key_valid(key_valid),
    .key_req(key_req), .busy(busy), .stage_sel(stage_sel), .capture(capture),
    .en_sr(en_sr), .en_mc(en_mc), .round(round), .phase_cnt(phase_cnt), .done(done)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   done_pulses = 0;
  exp_t exp_q[$];

  // Reference model: a phase schedule walked one cycle at a time
  int ph_kind[$];
  int ph_len[$];
  int ph_rnd[$];
  int m_mode = 0;   // 0 idle, 1 running schedule, 2 completion cycle
  int m_idx = 0;
  int m_pos = 0;
  int n_stall = 0;
  int accept_cyc = 0;
  int m_blocks = 0;
  bit blk_end = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic obs_t dut_obs();
    obs_t o;
    o.busy = busy; o.done = done; o.key_req = key_req; o.capture = capture;
    o.en_sr = en_sr; o.en_mc = en_mc; o.sel = stage_sel; o.rnd = round; o.cnt = phase_cnt;
    return o;
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic add_phase(input int k, input int l, input int r);
    ph_kind.push_back(k); ph_len.push_back(l); ph_rnd.push_back(r);
  endtask

  task automatic model_step(input bit st, input bit kv);
    exp_t e;
    int   kind;
    e.cyc = cyc;
    e.o   = '0;
    if (m_mode == 1) begin
      kind     = ph_kind[m_idx];
      e.o.busy = 1'b1;
      e.o.rnd  = 4'(ph_rnd[m_idx]);
      e.o.cnt  = 6'(m_pos);
      case (kind)
        K_INIT, K_ARK: begin
          e.o.key_req = 1'b1;
          e.o.capture = kv;
          e.o.sel     = (kind == K_INIT) ? 3'd1 : 3'd5;
        end
        K_SUB: begin
          e.o.capture = 1'b1;
          e.o.sel     = 3'd2;
        end
        K_SHIFT: begin
          e.o.en_sr   = 1'b1;
          e.o.capture = (m_pos >= SR_LAT);
          e.o.sel     = 3'd3;
        end
        default: begin
          e.o.en_mc   = !((m_pos % 4 == 0) && (m_pos < 16));
          e.o.capture = (m_pos >= MC_LAT);
          e.o.sel     = 3'd4;
        end
      endcase
      exp_q.push_back(e);
      if ((kind == K_INIT || kind == K_ARK) && !kv) n_stall++;
      else m_pos++;
      if (m_pos == ph_len[m_idx]) begin
        m_pos = 0;
        m_idx++;
        if (m_idx == ph_kind.size()) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      e.o.busy = 1'b1;
      e.o.done = 1'b1;
      e.o.rnd  = 4'(ROUNDS);
      exp_q.push_back(e);
      m_mode = 0;
      blk_end = 1'b1;
      m_blocks++;
    end else if (st) begin
      m_mode = 1; m_idx = 0; m_pos = 0; n_stall = 0;
      accept_cyc = cyc + 1;
    end
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1
  task automatic tick(input bit st, input bit kv);
    start     = st;
    key_valid = kv;
    model_step(st, kv);
    @(posedge clock); #1;
    if (blk_end) begin
      blk_end = 1'b0;
      check("block_latency", done_cyc - accept_cyc, BASE_LAT + n_stall);
      check("done_pulses_per_block", done_pulses, 1);
      done_pulses = 0;
    end
  endtask

  // Monitor: every busy cycle is an output the scoreboard must account for
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        vectors++; miscompares++;
        $display("FAIL missing_output cyc=%0d expected %h", exp_q[0].cyc, exp_q[0].o);
        void'(exp_q.pop_front());
      end
      if (busy) begin
        vectors++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          miscompares++;
          $display("FAIL unexpected_output cyc=%0d got %h", cyc, dut_obs());
        end else begin
          e = exp_q.pop_front();
          if (dut_obs() !== e.o) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d got %h expected %h (busy,done,key_req,capture,en_sr,en_mc,sel,round,phase_cnt)",
                     cyc, dut_obs(), e.o);
          end
        end
      end
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
      end
    end
  end

  // mode 0: plain + stray start in SUB of round 2; 1: 5-cycle key stall; 2: random key_valid
  task automatic run_block(input int mode);
    int stall_left;
    bit fired, st, kv, fin;
    stall_left = 0; fired = 0; fin = 0; st = 1;
    for (int k = 0; k < 3000; k++) begin
      kv = 1'b1;
      if (mode == 2) kv = ($urandom_range(0, 3) != 0);
      if (mode == 1 && !fired && m_mode == 1 && ph_kind[m_idx] == K_ARK &&
          ph_rnd[m_idx] == 3 && m_pos == 7) begin
        fired = 1; stall_left = 5;
      end
      if (stall_left > 0) begin kv = 1'b0; stall_left--; end
      if (mode == 0 && m_mode == 1 && ph_kind[m_idx] == K_SUB && ph_rnd[m_idx] == 2 && m_pos == 3)
        st = 1;
      tick(st, kv);
      st = 0;
      if (m_mode == 0) begin fin = 1; break; end
    end
    check("block_finished", int'(fin), 1);
  endtask

  task automatic run_reset_abort();
    bit hit;
    hit = 0;
    tick(1'b1, 1'b1);
    for (int k = 0; k < 2000; k++) begin
      if (m_mode == 1 && ph_kind[m_idx] == K_SHIFT && ph_rnd[m_idx] == 5 && m_pos == 5) begin
        hit = 1; break;
      end
      tick(1'b0, 1'b1);
    end
    check("reached_shift_round5", int'(hit), 1);
    #1 reset = 1'b1;
    #1 check_obs("async_reset_outputs", dut_obs(), '0);
    exp_q.delete();
    m_mode = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("no_done_after_abort", done_pulses, 0);
  endtask

  task automatic run_held();
    int idle_cnt, blocks0;
    bit seen, fin;
    idle_cnt = 0; seen = 0; fin = 0; blocks0 = m_blocks;
    for (int k = 0; k < 4000; k++) begin
      if (seen && !busy) idle_cnt++;
      tick(1'b1, 1'b1);
      if (m_mode != 0) seen = 1;
      if (m_blocks == blocks0 + 2) begin fin = 1; break; end
    end
    tick(1'b0, 1'b1);
    check("held_start_two_blocks", int'(fin), 1);
    check("idle_cycles_between_blocks", idle_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_valid = 1'b0;
    add_phase(K_INIT, 16, 0);
    for (int r = 1; r <= ROUNDS; r++) begin
      add_phase(K_SUB, 16, r);
      add_phase(K_SHIFT, SR_LAT + 16, r);
      if (r < ROUNDS) add_phase(K_MIX, MC_LAT + 16, r);
      add_phase(K_ARK, 16, r);
    end

    @(posedge clock); #1;
    check_obs("reset_outputs", dut_obs(), '0);
    key_valid = 1'b1; start = 1'b1;
    #1 check_obs("reset_outputs_inputs_high", dut_obs(), '0);
    @(posedge clock); #1;
    check_obs("reset_ignores_start", dut_obs(), '0);
    start = 1'b0;
    reset = 1'b0;
    tick(1'b0, 1'b1);
    check_obs("idle_after_reset", dut_obs(), '0);

    run_block(0);
    run_block(1);
    run_block(2);
    run_block(2);
    run_reset_abort();
    run_block(3);
    run_held();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
